// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle processor control FSM: decodes IR over steps T0..T3, drives
// register load enables, bus select and ALU op, counts retired instructions.
module proc_ctrl_fsm #(
  parameter int unsigned HALT_ON_ILLEGAL = 0,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [8:0]       IR,
  output logic             IRin,
  output logic [7:0]       Rin,
  output logic             Ain,
  output logic             Gin,
  output logic [1:0]       AluOp,
  output logic [3:0]       BusSel,
  output logic             Done,
  output logic [1:0]       Tstep,
  output logic             Halted,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [2:0] {
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;

  state_t     state, state_nxt;
  logic [2:0] op, rx, ry;
  logic [7:0] rx_onehot;

  assign op        = IR[8:6];
  assign rx        = IR[5:3];
  assign ry        = IR[2:0];
  assign rx_onehot = 8'd1 << rx;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_T0;
    else         state <= state_nxt;
  end

  // Next-state and control decode from state and IR
  always_comb begin
    state_nxt = state;
    IRin      = 1'b0;
    Rin       = '0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AluOp     = 2'b00;
    BusSel    = '0;
    Done      = 1'b0;
    Tstep     = 2'b00;
    Halted    = 1'b0;
    case (state)
      S_T0: begin
        if (Run) begin
          IRin      = 1'b1;
          BusSel    = SEL_DIN;
          state_nxt = S_T1;
        end
      end
      S_T1: begin
        Tstep = 2'd1;
        case (op)
          OP_MV: begin
            BusSel    = {1'b0, ry};
            Rin       = rx_onehot;
            Done      = 1'b1;
            state_nxt = S_T0;
          end
          OP_MVI: begin
            BusSel    = SEL_DIN;
            Rin       = rx_onehot;
            Done      = 1'b1;
            state_nxt = S_T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            BusSel    = {1'b0, rx};
            Ain       = 1'b1;
            state_nxt = S_T2;
          end
          default: begin
            if (HALT_ON_ILLEGAL != 0) begin
              state_nxt = S_HALT;
            end else begin
              Done      = 1'b1;
              state_nxt = S_T0;
            end
          end
        endcase
      end
      S_T2: begin
        Tstep  = 2'd2;
        BusSel = {1'b0, ry};
        Gin    = 1'b1;
        case (op)
          OP_SUB:  AluOp = 2'b01;
          OP_AND:  AluOp = 2'b10;
          default: AluOp = 2'b00;
        endcase
        state_nxt = S_T3;
      end
      S_T3: begin
        Tstep     = 2'd3;
        BusSel    = SEL_G;
        Rin       = rx_onehot;
        Done      = 1'b1;
        state_nxt = S_T0;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_nxt = S_T0;
    endcase
    // Outputs are forced low while reset is held, even though T0 would
    // otherwise decode Run straight through to IRin.
    if (!Resetn) begin
      IRin   = 1'b0;
      Rin    = '0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AluOp  = 2'b00;
      BusSel = '0;
      Done   = 1'b0;
      Tstep  = 2'b00;
      Halted = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)   Retired <= '0;
    else if (Done) Retired <= Retired + 1'b1;
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: directed vector table, hand-written
// corner sequences, then randomized instructions against a micro-op model.
module tb_proc_ctrl_fsm;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic [1:0] alu;
    logic [3:0] bus;
    logic       done;
    logic [1:0] ts;
    logic       halted;
  } outs_t;

  typedef struct {
    bit          run;
    logic [8:0]  ir;
    outs_t       e;
    int unsigned ret;
  } vec_t;

  localparam logic [20:0] FULL = '1;
  localparam logic [20:0] NOTS = 21'h1FFFF9;

  logic Clock = 1'b0;
  logic Resetn;
  logic Run;
  logic [8:0] IR;

  logic       irin_w [3];
  logic [7:0] rin_w  [3];
  logic       ain_w  [3];
  logic       gin_w  [3];
  logic [1:0] alu_w  [3];
  logic [3:0] bus_w  [3];
  logic       done_w [3];
  logic [1:0] ts_w   [3];
  logic       hlt_w  [3];
  logic [15:0] ret0, ret1;
  logic [3:0]  ret2;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  proc_ctrl_fsm #(.HALT_ON_ILLEGAL(0), .CNT_W(16)) u_h0 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(irin_w[0]), .Rin(rin_w[0]), .Ain(ain_w[0]), .Gin(gin_w[0]),
    .AluOp(alu_w[0]), .BusSel(bus_w[0]), .Done(done_w[0]), .Tstep(ts_w[0]),
    .Halted(hlt_w[0]), .Retired(ret0));

  proc_ctrl_fsm #(.HALT_ON_ILLEGAL(1), .CNT_W(16)) u_h1 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(irin_w[1]), .Rin(rin_w[1]), .Ain(ain_w[1]), .Gin(gin_w[1]),
    .AluOp(alu_w[1]), .BusSel(bus_w[1]), .Done(done_w[1]), .Tstep(ts_w[1]),
    .Halted(hlt_w[1]), .Retired(ret1));

  proc_ctrl_fsm #(.HALT_ON_ILLEGAL(0), .CNT_W(4)) u_c4 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(irin_w[2]), .Rin(rin_w[2]), .Ain(ain_w[2]), .Gin(gin_w[2]),
    .AluOp(alu_w[2]), .BusSel(bus_w[2]), .Done(done_w[2]), .Tstep(ts_w[2]),
    .Halted(hlt_w[2]), .Retired(ret2));

  function automatic outs_t o(bit irin, logic [7:0] rin, bit ain, bit gin,
                              logic [1:0] alu, logic [3:0] bus, bit done,
                              logic [1:0] ts, bit h);
    o = {irin, rin, ain, gin, alu, bus, done, ts, h};
  endfunction

  function automatic outs_t get_act(int i);
    get_act = {irin_w[i], rin_w[i], ain_w[i], gin_w[i], alu_w[i], bus_w[i],
               done_w[i], ts_w[i], hlt_w[i]};
  endfunction

  function automatic int unsigned get_ret(int i);
    case (i)
      0:       get_ret = ret0;
      1:       get_ret = ret1;
      default: get_ret = ret2;
    endcase
  endfunction

  task automatic chk_o(input string nm, input int i, input outs_t exp, input logic [20:0] mask);
    outs_t a;
    a = get_act(i);
    checks++;
    if ((a & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (mask %h) t=%0t", nm, i, a, exp, mask, $time);
    end
  endtask

  task automatic chk_r(input string nm, input int i, input int unsigned exp);
    int unsigned a;
    a = get_ret(i);
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s dut%0d Retired: got %0d expected %0d t=%0t", nm, i, a, exp, $time);
    end
  endtask

  // ---- instruction-level reference model ----
  // Each instruction is a short list of micro-steps following T0.
  function automatic bit is_illegal(logic [8:0] ir);
    is_illegal = (ir[8:6] > 3'd4);
  endfunction

  function automatic int ulen(logic [8:0] ir);
    if (ir[8:6] == 3'd0 || ir[8:6] == 3'd1 || is_illegal(ir)) ulen = 1;
    else ulen = 3;
  endfunction

  function automatic outs_t uop(logic [8:0] ir, int k, bit hcfg);
    logic [2:0] x, y;
    logic [7:0] oh;
    logic [1:0] alu;
    x   = ir[5:3];
    y   = ir[2:0];
    oh  = 8'd1 << x;
    alu = (ir[8:6] == 3'd3) ? 2'd1 : (ir[8:6] == 3'd4) ? 2'd2 : 2'd0;
    if (ir[8:6] == 3'd0)      uop = o(0, oh, 0, 0, 0, {1'b0, y}, 1, 1, 0);
    else if (ir[8:6] == 3'd1) uop = o(0, oh, 0, 0, 0, 4'd9, 1, 1, 0);
    else if (is_illegal(ir))  uop = o(0, 0, 0, 0, 0, 0, !hcfg, 1, 0);
    else if (k == 1)          uop = o(0, 0, 1, 0, 0, {1'b0, x}, 0, 1, 0);
    else if (k == 2)          uop = o(0, 0, 0, 1, alu, {1'b0, y}, 0, 2, 0);
    else                      uop = o(0, oh, 0, 0, 0, 4'd8, 1, 3, 0);
  endfunction

  int          pos  [2];
  bit          mhlt [2];
  int unsigned mret [2];

  function automatic outs_t mexp(int m);
    if (!Resetn)       mexp = '0;
    else if (mhlt[m])  mexp = o(0, 0, 0, 0, 0, 0, 0, 0, 1);
    else if (pos[m] == 0) mexp = Run ? o(1, 0, 0, 0, 0, 4'd9, 0, 0, 0) : '0;
    else               mexp = uop(IR, pos[m], m == 1);
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      pos[m] = 0; mhlt[m] = 0; mret[m] = 0;
    end
  endtask

  task automatic madv(input int m);
    outs_t e;
    if (!Resetn) begin
      pos[m] = 0; mhlt[m] = 0; mret[m] = 0;
    end else if (mhlt[m]) begin
      pos[m] = 0;
    end else if (pos[m] == 0) begin
      pos[m] = Run ? 1 : 0;
    end else begin
      e = uop(IR, pos[m], m == 1);
      if (e.done) mret[m]++;
      if (pos[m] == ulen(IR)) begin
        if (is_illegal(IR) && m == 1) mhlt[m] = 1;
        pos[m] = 0;
      end else begin
        pos[m]++;
      end
    end
  endtask

  function automatic vec_t v(bit run, logic [8:0] ir, outs_t e, int unsigned ret);
    v.run = run; v.ir = ir; v.e = e; v.ret = ret;
  endfunction

  vec_t  tbl [27];
  outs_t t0e, z;

  initial begin
    logic [8:0] a, b, c, d, e, f, g, h, ir;
    logic [2:0] op;
    int r;

    t0e = o(1, 0, 0, 0, 0, 4'd9, 0, 0, 0);
    z   = '0;
    a = 9'b001_011_000; b = 9'b011_001_110; c = 9'b000_010_101;
    d = 9'b000_111_000; e = 9'b000_000_111; f = 9'b111_000_000;
    g = 9'b010_010_010; h = 9'b100_011_100;
    tbl[0]  = v(1, a, t0e, 0);
    tbl[1]  = v(0, a, o(0, 8'h08, 0, 0, 0, 9, 1, 1, 0), 0);
    tbl[2]  = v(0, a, z, 1);
    tbl[3]  = v(1, b, t0e, 1);
    tbl[4]  = v(0, b, o(0, 0, 1, 0, 0, 1, 0, 1, 0), 1);
    tbl[5]  = v(0, b, o(0, 0, 0, 1, 1, 6, 0, 2, 0), 1);
    tbl[6]  = v(0, b, o(0, 8'h02, 0, 0, 0, 8, 1, 3, 0), 1);
    tbl[7]  = v(1, c, t0e, 2);
    tbl[8]  = v(1, c, o(0, 8'h04, 0, 0, 0, 5, 1, 1, 0), 2);
    tbl[9]  = v(1, d, t0e, 3);
    tbl[10] = v(1, d, o(0, 8'h80, 0, 0, 0, 0, 1, 1, 0), 3);
    tbl[11] = v(1, e, t0e, 4);
    tbl[12] = v(1, e, o(0, 8'h01, 0, 0, 0, 7, 1, 1, 0), 4);
    tbl[13] = v(0, e, z, 5);
    tbl[14] = v(1, f, t0e, 5);
    tbl[15] = v(0, f, o(0, 0, 0, 0, 0, 0, 1, 1, 0), 5);
    tbl[16] = v(0, f, z, 6);
    tbl[17] = v(1, g, t0e, 6);
    tbl[18] = v(0, g, o(0, 0, 1, 0, 0, 2, 0, 1, 0), 6);
    tbl[19] = v(0, g, o(0, 0, 0, 1, 0, 2, 0, 2, 0), 6);
    tbl[20] = v(0, g, o(0, 8'h04, 0, 0, 0, 8, 1, 3, 0), 6);
    tbl[21] = v(0, g, z, 7);
    tbl[22] = v(1, h, t0e, 7);
    tbl[23] = v(0, h, o(0, 0, 1, 0, 0, 3, 0, 1, 0), 7);
    tbl[24] = v(0, h, o(0, 0, 0, 1, 2, 4, 0, 2, 0), 7);
    tbl[25] = v(0, h, o(0, 8'h08, 0, 0, 0, 8, 1, 3, 0), 7);
    tbl[26] = v(0, h, z, 8);

    // Reset with Run high: every output must still be low
    Resetn = 1'b0; Run = 1'b1; IR = '1;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk_o("reset_outs", i, z, FULL);
      chk_r("reset_ret", i, 0);
    end

    // Directed vector table on the HALT_ON_ILLEGAL=0 instance
    for (int i = 0; i < 27; i++) begin
      @(negedge Clock);
      Resetn = 1'b1; Run = tbl[i].run; IR = tbl[i].ir;
      #1;
      chk_o($sformatf("tbl%0d", i), 0, tbl[i].e, FULL);
      chk_r($sformatf("tbl%0d", i), 0, tbl[i].ret);
    end

    // Reset in T2 of add R0,R1 aborts without an Rin pulse
    @(negedge Clock); Resetn = 1'b0; Run = 1'b0;
    @(negedge Clock); Resetn = 1'b1; Run = 1'b1; IR = 9'b010_000_001;
    #1 chk_o("abort_t0", 0, t0e, FULL);
    @(negedge Clock); Run = 1'b0;
    #1 chk_o("abort_t1", 0, o(0, 0, 1, 0, 0, 0, 0, 1, 0), FULL);
    @(negedge Clock);
    #1 chk_o("abort_t2", 0, o(0, 0, 0, 1, 0, 1, 0, 2, 0), FULL);
    #2 Resetn = 1'b0; Run = 1'b1;
    #1 chk_o("abort_rst", 0, z, FULL);
    chk_r("abort_rst", 0, 0);
    @(negedge Clock); Resetn = 1'b1; Run = 1'b0;
    #1 chk_o("abort_after1", 0, z, FULL);
    chk_r("abort_after1", 0, 0);
    @(negedge Clock);
    #1 chk_o("abort_after2", 0, z, FULL);
    chk_r("abort_after2", 0, 0);

    // Illegal opcode: NOP on dut0, parks dut1 in HALT until reset
    @(negedge Clock); Resetn = 1'b0;
    @(negedge Clock); Resetn = 1'b1; Run = 1'b1; IR = 9'b111_000_000;
    #1 chk_o("ill_t0", 1, t0e, FULL);
    @(negedge Clock); Run = 1'b0;
    #1 chk_o("ill_t1_halt", 1, o(0, 0, 0, 0, 0, 0, 0, 1, 0), FULL);
    chk_o("ill_t1_nop", 0, o(0, 0, 0, 0, 0, 0, 1, 1, 0), FULL);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock); Run = i[0];
      #1 chk_o("halt_hold", 1, o(0, 0, 0, 0, 0, 0, 0, 0, 1), NOTS);
      chk_r("halt_hold", 1, 0);
    end
    @(negedge Clock); Resetn = 1'b0;
    #1 chk_o("halt_rst", 1, z, FULL);

    // 17 back-to-back mv on the 4-bit counter instance: wraps to 1
    for (int n = 0; n < 17; n++) begin
      @(negedge Clock); Resetn = 1'b1; Run = 1'b1;
      IR = {3'b000, 3'(n % 8), 3'((n + 3) % 8)};
      #1 chk_o("wrap_t0", 2, t0e, FULL);
      chk_r("wrap_t0", 2, n % 16);
      @(negedge Clock);
      #1 chk_o("wrap_t1", 2, o(0, 8'd1 << (n % 8), 0, 0, 0, 4'((n + 3) % 8), 1, 1, 0), FULL);
    end
    @(negedge Clock); Run = 1'b0;
    #1 chk_r("wrap_final", 2, 1);
    chk_r("wrap_final16", 0, 17);

    // Randomized instruction stream against the model
    @(negedge Clock); Resetn = 1'b0; mreset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge Clock);
      Resetn = ($urandom_range(0, 49) != 0);
      if (!Resetn) mreset();
      Run = ($urandom_range(0, 3) != 0);
      if (pos[0] == 0 && pos[1] == 0) begin
        r  = $urandom_range(0, 15);
        op = (r < 14) ? 3'(r % 5) : 3'(5 + r - 14);
        ir = {op, 6'($urandom)};
        IR = ir;
      end
      #1;
      chk_o("rand", 0, mexp(0), FULL);
      chk_o("rand", 1, mexp(1), mhlt[1] ? NOTS : FULL);
      chk_o("rand", 2, mexp(0), FULL);
      chk_r("rand", 0, mret[0] % 65536);
      chk_r("rand", 1, mret[1] % 65536);
      chk_r("rand", 2, mret[0] % 16);
      @(posedge Clock);
      madv(0);
      madv(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
PROC_CTRL_FSM -- requirements
Module: proc_ctrl_fsm

Interface
REQ-001 Parameter: HALT_ON_ILLEGAL, 0, when 1 an illegal opcode parks the FSM in HALT until reset; when 0 it completes as a one-step NOP.
REQ-002 Parameter: CNT_W, 16, width of the instruction-retired counter.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  start request, sampled only in T0.
REQ-006 IR  input  9  instruction register contents, format III XXX YYY (IR[8:6] opcode, IR[5:3] X, IR[2:0] Y).
REQ-007 IRin  output  1  load enable for the IR register.
REQ-008 Rin  output  8  one-hot load enables for R0..R7 (Rin[k] loads Rk).
REQ-009 Ain  output  1  load enable for the A register.
REQ-010 Gin  output  1  load enable for the G register.
REQ-011 AluOp  output  2  00 add, 01 sub, 10 and, 11 unused.
REQ-012 BusSel  output  4  bus mux select: 0-7 = R0-R7, 8 = G, 9 = DIN.
REQ-013 Done  output  1  asserted in the final step of each instruction.
REQ-014 Tstep  output  2  current time step (00=T0 ... 11=T3), for debug.
REQ-015 Halted  output  1  high while in HALT.
REQ-016 Retired  output  CNT_W  count of instructions that asserted Done.

Function
REQ-017 States: T0, T1, T2, T3, HALT; all control outputs are combinational decodes of state and IR. Unlisted outputs are 0.
REQ-018 T0: IRin=1 and BusSel=9 whenever Run=1, with a transition to T1. With Run=0, all outputs are 0 and the FSM stays in T0.
REQ-019 Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101-111 illegal.
REQ-020 mv T1: BusSel=Y, Rin[X]=1, Done=1, next T0.
REQ-021 mvi T1: BusSel=9, Rin[X]=1, Done=1, next T0.
REQ-022 add/sub/and T1: BusSel=X, Ain=1, next T2.
REQ-023 add/sub/and T2: BusSel=Y, Gin=1, AluOp per opcode (010->00, 011->01, 100->10), next T3.
REQ-024 add/sub/and T3: BusSel=8, Rin[X]=1, Done=1, next T0.
REQ-025 Illegal in T1 with HALT_ON_ILLEGAL=0: Done=1, no enables, next T0.
REQ-026 Illegal in T1 with HALT_ON_ILLEGAL=1: Done=0, no enables, next HALT.
REQ-027 HALT: all control outputs 0, Halted=1, Run ignored; exit only by reset.
REQ-028 X=Y is legal; e.g. add R2,R2 takes BusSel=2 in both T1 and T2.
REQ-029 Exactly one of Rin[7:0] may be high in any cycle; Rin is never asserted in T0 or T2.
REQ-030 Done is high for exactly one cycle per instruction; Done always leads to T0 on the next edge.
REQ-031 Run held high keeps instructions issuing back-to-back: T0 follows Done with no idle cycle, and IRin=1 in that T0.
REQ-032 Retired increments by 1 on each clock edge where Done=1, wrapping from 2^CNT_W-1 to 0.
REQ-033 Latency: mv/mvi/NOP take 2 cycles including T0; add/sub/and take 4 cycles.
REQ-034 IR must stay stable from T1 to Done; the FSM does not latch IR.

Reset
REQ-035 Resetn=0 asynchronously forces state T0 and Retired=0, regardless of the current state.
REQ-036 While Resetn=0, all outputs are 0: IRin, Rin, Ain, Gin, AluOp, BusSel, Done, Tstep, Halted.
REQ-037 Reset asserted mid-instruction, including at T2 or T3, aborts the instruction with no Rin pulse and no Retired increment.
REQ-038 After Resetn rises, the first possible IRin occurs on the first cycle with Run=1.

Verification
REQ-039 IR=001_011_000, Run=1 -> T0: IRin=1, BusSel=9; T1: BusSel=9, Rin=00001000, Done=1; Retired 0->1.
REQ-040 IR=011_001_110 (sub R1,R6) -> T1: BusSel=1, Ain=1; T2: BusSel=6, Gin=1, AluOp=01; T3: BusSel=8, Rin=00000010, Done=1.
REQ-041 Run held high, three consecutive mv ops -> Done high every second cycle, IRin in each intervening T0, Retired=3.
REQ-042 IR=111_000_000: with HALT_ON_ILLEGAL=0 -> Done=1 in T1, Rin=0; with HALT_ON_ILLEGAL=1 -> Halted=1, Done=0, Run pulses ignored for 10 cycles.
REQ-043 Resetn pulsed low during T2 of add R0,R1 -> outputs 0 immediately, no Rin[0] pulse, Tstep=00, Retired unchanged at 0.
REQ-044 CNT_W=4, 17 mv instructions -> Retired wraps 15->0, ending at 1.
